bp_resolve_queue: RTL and testbench
===================================

# bp_resolve_queue

Tracks every branch/jump prediction issued at fetch until the execute stage resolves it. Compares prediction against outcome, raises a registered mispredict/redirect, and emits the training strobe (`upd_*`) that drives the perceptron predictor's `ex_br_*` update inputs. Sits between the predictor/fetch boundary and the EX branch unit.

## Interface

Parameters:
- `Depth`, default 4: queue entries. Must be a power of 2, at least 2.
- `PtrW`, default `$clog2(Depth)`: pointer width. Derived; do not override.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `pred_valid_i`  in  1  fetch issues a prediction for a branch/jump
- `pred_ready_o`  out  1  queue can accept; equals `~full`
- `pred_pc_i`  in  32  PC of predicted instruction
- `pred_taken_i`  in  1  predicted direction
- `pred_target_i`  in  32  predicted target
- `res_valid_i`  in  1  EX resolves one branch/jump this cycle
- `res_pc_i`  in  32  PC of resolved instruction
- `res_taken_i`  in  1  actual direction
- `res_target_i`  in  32  actual taken target
- `res_compressed_i`  in  1  resolved instruction is 16-bit
- `flush_i`  in  1  external pipeline flush
- `upd_valid_o`  out  1  training strobe to predictor
- `upd_pc_o`  out  32  PC to train
- `upd_taken_o`  out  1  outcome to train
- `mispredict_o`  out  1  one-cycle redirect request
- `redirect_pc_o`  out  32  correct next PC
- `orphan_o`  out  1  resolve had no matching queue head
- `count_o`  out  `PtrW+1`  occupied entries

## Operation

- Storage: circular buffer of `{pc, taken, target}`. Uses head pointer, tail pointer, and an occupancy counter (0..`Depth`). `full` = (count == `Depth`). `empty` = (count == 0).
- Enqueue: when `pred_valid_i & pred_ready_o & ~flush_i & ~mispredict_pending`, write at tail and increment tail. No write-through bypass.
- Resolve, queue non-empty and head.pc == `res_pc_i`:
  - Pop head.
  - `mis = (head.taken != res_taken_i) | (res_taken_i & head.target != res_target_i)`.
- Resolve, queue empty or PC mismatch:
  - Orphan. Nothing popped.
  - If the queue is non-empty, all entries are discarded as stale.
  - `mis = res_taken_i`, i.e. the prediction is treated as not-taken.
  - `orphan_o` pulses.
- Every resolve, matched or orphan, produces `upd_valid_o = 1`, `upd_pc_o = res_pc_i`, `upd_taken_o = res_taken_i`.
- Redirect:
  - `redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + (res_compressed_i ? 2 : 4)`, truncated to 32 bits.
  - `mispredict_o = mis`.
- Mispredict: all surviving entries are younger, wrong-path predictions. The queue clears at the same edge the outputs register.
  - `mispredict_pending` is the internal combinational `res_valid_i & mis`. It blocks same-cycle enqueue.
- `flush_i`: clears the queue at the next edge and drops any same-cycle enqueue.
  - A same-cycle resolve still generates `upd_*`, `mispredict_o` and `orphan_o`, because the resolve is older than the flush.
- Pointer and count arithmetic wraps modulo `Depth`. The counter never exceeds `Depth` or goes below 0.

## Timing

- Reset (async assert, sync-to-clock deassert assumed upstream):
  - Pointers, count and all registered outputs are 0.
  - `pred_ready_o` = 1.
  - Entry contents are don't-care.
- `upd_*`, `mispredict_o`, `redirect_pc_o`, `orphan_o`: registered, one cycle after `res_valid_i`. Strobes last exactly one cycle. Data outputs hold their last value when not strobed.
- `pred_ready_o`, `count_o`: combinational from registered state. They do not depend on same-cycle `res_valid_i`, so a full queue refuses enqueue even while popping.
- Enqueue and matched pop in the same cycle: count is unchanged; both pointers advance.
- Enqueue on an empty queue with a same-cycle resolve: the resolve is an orphan and the enqueue is accepted, unless it is blocked by the mispredict.
- Reset asserted mid-operation: the queue empties immediately, and any pending output strobe is lost.

## Structure

- `bp_pkg` holds:
  - `bp_pred_entry_t` packed struct `{logic [31:0] pc; logic taken; logic [31:0] target;}`.
  - Localparams `BP_ILEN_C = 2` and `BP_ILEN_U = 4`.
- Sub-module `bp_inflight_fifo` is a generic circular buffer with push, pop, clear, count, full and empty. Compare, redirect and output registers stay in the top module.

## Test plan

- Reset → `pred_ready_o=1`, `count_o=0`, all strobes 0.
- Enqueue `{0x100, taken, 0x140}`, then resolve `0x100` taken target `0x140` → next cycle `upd_valid_o=1`, `upd_pc_o=0x100`, `mispredict_o=0`, `count_o=0`.
- Enqueue `{0x200, not-taken}` and `{0x204, taken, 0x300}`, then resolve `0x200` taken target `0x280` → `mispredict_o=1`, `redirect_pc_o=0x280`, `count_o=0` (entry `0x204` discarded).
- Resolve `0x210` not-taken, compressed, with the queue empty → `orphan_o=1`, `mispredict_o=0`, `upd_taken_o=0`. Repeat as taken → `mispredict_o=1`.
- Fill 4 entries → `pred_ready_o=0`. Enqueue attempt plus matched resolve in the same cycle → `count_o=3` and the attempted entry is absent. Then verify pointer wrap over 8 more push/pop pairs.
- `flush_i` with a same-cycle enqueue and a matched resolve → `upd_valid_o=1`, `count_o=0`, and the new entry is not stored.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-prediction resolve queue.
package bp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_pred_entry_t;

  localparam logic [31:0] BP_ILEN_C = 32'd2;
  localparam logic [31:0] BP_ILEN_U = 32'd4;

endpackage

// File: rtl/bp_inflight_fifo.sv
// Generic circular buffer with push/pop/clear; head entry is presented combinationally.
module bp_inflight_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 65,
  parameter int unsigned PtrW  = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [Width-1:0] head_o,
  output logic [PtrW:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      // Clear collapses the queue onto the tail so a same-cycle push lands as the sole entry.
      head_d  = tail_q;
      tail_d  = tail_q + PtrW'(push_i);
      count_d = (PtrW+1)'(push_i);
    end else begin
      tail_d  = tail_q + PtrW'(push_i);
      head_d  = head_q + PtrW'(pop_i);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DepthC);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bp_resolve_queue.sv
// Tracks in-flight branch predictions, compares them with EX outcomes and
// registers the redirect and predictor-training strobes.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pred_valid_i,
  output logic            pred_ready_o,
  input  logic [31:0]     pred_pc_i,
  input  logic            pred_taken_i,
  input  logic [31:0]     pred_target_i,
  input  logic            res_valid_i,
  input  logic [31:0]     res_pc_i,
  input  logic            res_taken_i,
  input  logic [31:0]     res_target_i,
  input  logic            res_compressed_i,
  input  logic            flush_i,
  output logic            upd_valid_o,
  output logic [31:0]     upd_pc_o,
  output logic            upd_taken_o,
  output logic            mispredict_o,
  output logic [31:0]     redirect_pc_o,
  output logic            orphan_o,
  output logic [PtrW:0]   count_o
);

  bp_pred_entry_t head, wr_entry;
  logic           full, empty;
  logic           match, orphan, mis, mis_pending;
  logic           push, pop, clear;
  logic [31:0]    redirect_pc;

  logic        upd_valid_q, upd_taken_q, mispredict_q, orphan_q;
  logic [31:0] upd_pc_q, redirect_pc_q;

  assign wr_entry = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};

  always_comb begin
    match       = res_valid_i & ~empty & (head.pc == res_pc_i);
    orphan      = res_valid_i & ~match;
    mis         = match ? ((head.taken != res_taken_i) |
                           (res_taken_i & (head.target != res_target_i)))
                        : res_taken_i;
    mis_pending = res_valid_i & mis;
    push        = pred_valid_i & ~full & ~flush_i & ~mis_pending;
    pop         = match;
    // An orphan on a non-empty queue means every tracked entry is stale.
    clear       = flush_i | mis_pending | (orphan & ~empty);
    redirect_pc = res_taken_i ? res_target_i
                              : res_pc_i + (res_compressed_i ? BP_ILEN_C : BP_ILEN_U);
  end

  bp_inflight_fifo #(
    .Depth (Depth),
    .Width ($bits(bp_pred_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .clear_i (clear),
    .head_o  (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      orphan_q      <= 1'b0;
    end else begin
      upd_valid_q  <= res_valid_i;
      mispredict_q <= mis_pending;
      orphan_q     <= orphan;
      if (res_valid_i) begin
        upd_pc_q      <= res_pc_i;
        upd_taken_q   <= res_taken_i;
        redirect_pc_q <= redirect_pc;
      end
    end
  end

  assign pred_ready_o  = ~full;
  assign upd_valid_o   = upd_valid_q;
  assign upd_pc_o      = upd_pc_q;
  assign upd_taken_o   = upd_taken_q;
  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_pc_q;
  assign orphan_o      = orphan_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue with a queue-based reference model.
module tb_bp_resolve_queue;
  import bp_pkg::*;

  localparam int unsigned Depth = 4;

  logic        clk, rst_n;
  logic        pred_valid, pred_ready, pred_taken;
  logic [31:0] pred_pc, pred_target;
  logic        res_valid, res_taken, res_compressed, flush;
  logic [31:0] res_pc, res_target;
  logic        upd_valid, upd_taken, mispredict, orphan;
  logic [31:0] upd_pc, redirect_pc;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bp_resolve_queue #(.Depth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pred_valid_i(pred_valid), .pred_ready_o(pred_ready),
    .pred_pc_i(pred_pc), .pred_taken_i(pred_taken), .pred_target_i(pred_target),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_taken_i(res_taken),
    .res_target_i(res_target), .res_compressed_i(res_compressed),
    .flush_i(flush),
    .upd_valid_o(upd_valid), .upd_pc_o(upd_pc), .upd_taken_o(upd_taken),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .orphan_o(orphan), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of predictions plus the last registered outputs.
  bp_pred_entry_t mq[$];
  logic        m_upd_valid, m_upd_taken, m_mis, m_orphan;
  logic [31:0] m_upd_pc, m_redirect;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_upd_valid = 0; m_upd_taken = 0; m_mis = 0; m_orphan = 0;
      m_upd_pc = 0; m_redirect = 0;
    end else begin
      bp_pred_entry_t e;
      bit was_full, mis, orph, accept;
      was_full = (mq.size() == Depth);
      mis = 0; orph = 0;
      if (res_valid) begin
        if (mq.size() > 0 && mq[0].pc == res_pc) begin
          e = mq.pop_front();
          mis = (e.taken != res_taken) || (res_taken && e.target != res_target);
        end else begin
          orph = 1;
          mis = res_taken;
          mq.delete();
        end
        m_upd_pc   = res_pc;
        m_upd_taken = res_taken;
        m_redirect = res_taken ? res_target : res_pc + (res_compressed ? 32'd2 : 32'd4);
      end
      accept = pred_valid && !was_full && !flush && !(res_valid && mis);
      if (flush || (res_valid && mis)) mq.delete();
      if (accept) mq.push_back('{pc: pred_pc, taken: pred_taken, target: pred_target});
      m_upd_valid = res_valid;
      m_mis       = res_valid && mis;
      m_orphan    = orph;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_count", 32'(count), 32'(mq.size()));
      chk("cmp_ready", 32'(pred_ready), 32'(mq.size() < Depth));
      chk("cmp_upd_valid", 32'(upd_valid), 32'(m_upd_valid));
      chk("cmp_upd_pc", upd_pc, m_upd_pc);
      chk("cmp_upd_taken", 32'(upd_taken), 32'(m_upd_taken));
      chk("cmp_mispredict", 32'(mispredict), 32'(m_mis));
      chk("cmp_redirect", redirect_pc, m_redirect);
      chk("cmp_orphan", 32'(orphan), 32'(m_orphan));
    end
  end

  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtg, input logic rc,
                      input logic fl);
    @(negedge clk);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    res_compressed = rc; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rpc;
    rst_n = 0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
    res_compressed = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(pred_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_mis", 32'(mispredict), 0);
    chk("rst_orphan", 32'(orphan), 0);
    @(negedge clk);
    rst_n = 1;

    // Matched, correctly predicted taken branch
    step(1, 32'h100, 1, 32'h140, 0, 0, 0, 0, 0, 0);
    chk("t1_count_after_push", 32'(count), 1);
    step(0, 0, 0, 0, 1, 32'h100, 1, 32'h140, 0, 0);
    chk("t1_upd_valid", 32'(upd_valid), 1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_mis", 32'(mispredict), 0);
    chk("t1_count", 32'(count), 0);
    idle();
    chk("t1_strobe_one_cycle", 32'(upd_valid), 0);

    // Direction mispredict discards the younger entry
    step(1, 32'h200, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h204, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    chk("t2_count_2", 32'(count), 2);
    step(0, 0, 0, 0, 1, 32'h200, 1, 32'h280, 0, 0);
    chk("t2_mis", 32'(mispredict), 1);
    chk("t2_redirect", redirect_pc, 32'h280);
    chk("t2_count", 32'(count), 0);

    // Orphans on an empty queue
    step(0, 0, 0, 0, 1, 32'h210, 0, 32'h0, 1, 0);
    chk("t3_orphan", 32'(orphan), 1);
    chk("t3_mis", 32'(mispredict), 0);
    chk("t3_upd_taken", 32'(upd_taken), 0);
    chk("t3_redirect_c", redirect_pc, 32'h212);
    step(0, 0, 0, 0, 1, 32'h210, 1, 32'h400, 1, 0);
    chk("t3_mis_taken", 32'(mispredict), 1);
    chk("t3_redirect_t", redirect_pc, 32'h400);
    idle();
    chk("t3_redirect_hold", redirect_pc, 32'h400);

    // Fill, refuse enqueue while popping, then wrap pointers
    for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(4*i), 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_full_ready", 32'(pred_ready), 0);
    chk("t4_full_count", 32'(count), 4);
    step(1, 32'h500, 0, 0, 1, 32'h300, 0, 0, 0, 0);
    chk("t4_count_3", 32'(count), 3);
    chk("t4_no_mis", 32'(mispredict), 0);
    for (int i = 0; i < 8; i++) begin
      rpc = (i < 3) ? 32'h304 + 32'(4*i) : 32'h600 + 32'(4*(i-3));
      step(1, 32'h600 + 32'(4*i), 0, 0, 1, rpc, 0, 0, 0, 0);
      chk("t4_wrap_orphan", 32'(orphan), 0);
      chk("t4_wrap_count", 32'(count), 3);
    end

    // Flush with same-cycle enqueue and matched resolve
    step(1, 32'h700, 0, 0, 1, 32'h614, 0, 0, 0, 1);
    chk("t5_upd_valid", 32'(upd_valid), 1);
    chk("t5_upd_pc", upd_pc, 32'h614);
    chk("t5_count", 32'(count), 0);
    step(0, 0, 0, 0, 1, 32'h700, 0, 0, 0, 0);
    chk("t5_not_stored", 32'(orphan), 1);

    // Orphan on non-empty queue discards stale entries
    step(1, 32'h900, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h950, 0, 0, 0, 0);
    chk("t6_orphan", 32'(orphan), 1);
    chk("t6_count", 32'(count), 0);

    // Mid-operation reset drops queue and pending strobe
    step(1, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h804, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    pred_valid = 0; res_valid = 1; res_pc = 32'h800; res_taken = 1; res_target = 32'h880;
    #1 rst_n = 0;
    #1;
    chk("t7_rst_count", 32'(count), 0);
    chk("t7_rst_ready", 32'(pred_ready), 1);
    @(posedge clk);
    #1;
    chk("t7_rst_no_strobe", 32'(upd_valid), 0);
    @(negedge clk);
    res_valid = 0;
    rst_n = 1;
    idle();
    chk("t7_after_rst_mis", 32'(mispredict), 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
